svm_stream_demux: RTL and testbench
===================================

Name: svm_stream_demux

Overview:
- 1-to-2 packet stream demultiplexer for the SVM datapath; the steering counterpart of the 2:1 operand mux.
- Takes one valid/ready stream of bitwidth-wide SVM words (accumulator results / feature vectors) and routes whole packets to lane A or lane B.
- Each lane has a one-entry registered output stage; the lane is chosen by a select sampled on the first beat of each packet.

Parameters:
- bitwidth, 25, data word width (matches SVM accumulator width)
- CNT_W, 16, width of per-lane packet counters (used only with SVM_DEMUX_STATS_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  bitwidth  input word
- in_valid  in  1  input word valid
- in_last  in  1  final word of packet
- in_sel  in  1  lane select, 0 = A, 1 = B; sampled only on the first beat of a packet
- in_ready  out  1  input accepted when in_valid && in_ready
- outA_data  out  bitwidth  lane A word
- outA_valid  out  1  lane A valid
- outA_last  out  1  lane A end of packet
- outA_ready  in  1  lane A consumer ready
- outB_data  out  bitwidth  lane B word
- outB_valid  out  1  lane B valid
- outB_last  out  1  lane B end of packet
- outB_ready  in  1  lane B consumer ready
- pkt_cnt_a  out  CNT_W  packets completed on A (only with SVM_DEMUX_STATS_EN)
- pkt_cnt_b  out  CNT_W  packets completed on B (only with SVM_DEMUX_STATS_EN)

Behaviour:
- Reset (async, rst_n low): state = IDLE, lock cleared, outA/outB valid = 0, data/last = 0, counters = 0.
- Reset mid-packet discards the buffered words and the lock. The next accepted beat after release is treated as a packet start.
- FSM states: IDLE, ROUTE_A, ROUTE_B.
  - IDLE: the target lane is in_sel.
  - Accepted beat with in_last = 0: go to ROUTE_A (sel = 0) or ROUTE_B (sel = 1).
  - Accepted beat with in_last = 1 (single-beat packet): stay in IDLE.
  - ROUTE_x: target is lane x regardless of in_sel. An accepted beat with in_last = 1 returns to IDLE.
- Lane stage (per lane x):
  - slot_free_x = !outx_valid || outx_ready.
  - in_ready = slot_free of the target lane only. The other lane's backpressure never blocks the input.
  - On acceptance, the target lane registers data/last and sets valid the next cycle. Latency is 1 cycle from accept to outx_valid.
  - outx_valid clears when outx_ready && outx_valid and no new word is loaded in the same cycle.
  - Simultaneous drain and load: the register is overwritten and valid stays 1, sustaining 1 word/cycle throughput.
- Output registers are stable while valid && !ready (AXI-stream style). A word is never dropped or duplicated.
- in_valid low: no state change. in_sel and in_data are don't-care.
- The non-target lane keeps draining independently while the input is stalled or routed elsewhere.
- Word order within a lane is preserved. Packets never interleave across a lane.

Optional Feature:
- Macro SVM_DEMUX_STATS_EN.
- Defined: pkt_cnt_a / pkt_cnt_b increment by 1 when a word with last = 1 is accepted into that lane (at input acceptance). They wrap modulo 2^CNT_W and clear on reset.
- Undefined: the counter logic and ports are absent.

Decomposition:
- Shared package/header svm_defs holds:
  - default SVM data width (25)
  - lane encodings LANE_A = 0, LANE_B = 1
  - FSM state encodings IDLE = 2'd0, ROUTE_A = 2'd1, ROUTE_B = 2'd2
- Sub-module svm_stream_reg: one-entry valid/ready register slice (data + last). It is instantiated twice, one per lane.

Test Plan:
- Route test: reset, send 3-beat packet 0x000001/0x000002/0x000003 (last on beat 3) with in_sel = 0, both readys high → outA carries the words 1 cycle after each accept, last on the third. outB_valid stays 0.
- Select lock: 4-beat packet starting with in_sel = 1, then toggle in_sel on every later beat → all 4 words appear on B. The next packet with in_sel = 0 goes to A.
- Independent backpressure: hold outA_ready = 0 with A full; send a packet to B → B accepts at 1 word/cycle. A's stalled word 0x0ABCDE is held unchanged until outA_ready = 1.
- Single-beat packets: alternating in_sel = 0, 1, 0, 1 with in_last = 1 each beat, both readys high → words alternate A/B back-to-back with no bubbles. FSM remains IDLE.
- Reset mid-packet: assert rst_n = 0 after beat 2 of a 5-beat packet to B → outB_valid drops immediately. After release, a new beat with in_sel = 0 goes to A.
- Stats (SVM_DEMUX_STATS_EN): send 3 packets to A and 2 to B → pkt_cnt_a = 3, pkt_cnt_b = 2. Preload by sending 2^CNT_W packets to A → pkt_cnt_a wraps to 0.

Source files
------------

// File: rtl/svm_defs_pkg.sv
// ----------------------------------------------------------------------------
// svm_defs_pkg
// Shared definitions for the SVM stream steering blocks:
//   SVM_DATA_W      default SVM word width (accumulator width)
//   LANE_A / LANE_B lane select encodings
//   state_t         packet-routing FSM states
// ----------------------------------------------------------------------------
package svm_defs_pkg;

    localparam int SVM_DATA_W = 25;

    localparam logic LANE_A = 1'b0;
    localparam logic LANE_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_A = 2'd1,
        ROUTE_B = 2'd2
    } state_t;

endpackage

// File: rtl/svm_stream_reg.sv
// ----------------------------------------------------------------------------
// svm_stream_reg
// One-entry valid/ready register slice carrying a data word and a last flag.
// The parent only asserts load when slot_free is high, so a held word is never
// overwritten before it has been taken.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         write load_data/load_last into the slot this cycle
//   load_data    word to store
//   load_last    end-of-packet flag to store
//   slot_free    slot can accept a word this cycle (empty or draining)
//   out_data     registered word
//   out_valid    registered word is valid
//   out_last     registered end-of-packet flag
//   out_ready    downstream consumer ready
// ----------------------------------------------------------------------------
module svm_stream_reg
    import svm_defs_pkg::*;
#(
    parameter int bitwidth = SVM_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [bitwidth-1:0] load_data,
    input  logic                load_last,
    output logic                slot_free,
    output logic [bitwidth-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
);

    assign slot_free = !out_valid || out_ready;

    // A load during a drain overwrites the slot and keeps valid high, which
    // is what sustains one word per cycle through the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/svm_stream_demux.sv
// ----------------------------------------------------------------------------
// svm_stream_demux
// 1-to-2 packet demultiplexer for SVM word streams. The lane is taken from
// in_sel on the first beat of a packet and locked until the beat with in_last.
// Each lane has its own one-entry register slice; only the target lane's
// backpressure can stall the input.
//
// Optional feature: define SVM_DEMUX_STATS_EN to add per-lane packet counters
// (pkt_cnt_a / pkt_cnt_b) that count accepted last-beats per lane.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready   input stream
//   in_sel                              lane select on first beat (0=A, 1=B)
//   outA_data/valid/last, outA_ready    lane A stream
//   outB_data/valid/last, outB_ready    lane B stream
//   pkt_cnt_a, pkt_cnt_b                packet counters (SVM_DEMUX_STATS_EN)
// ----------------------------------------------------------------------------
module svm_stream_demux
    import svm_defs_pkg::*;
#(
    parameter int bitwidth = SVM_DATA_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [bitwidth-1:0] in_data,
    input  logic                in_valid,
    input  logic                in_last,
    input  logic                in_sel,
    output logic                in_ready,
    output logic [bitwidth-1:0] outA_data,
    output logic                outA_valid,
    output logic                outA_last,
    input  logic                outA_ready,
    output logic [bitwidth-1:0] outB_data,
    output logic                outB_valid,
    output logic                outB_last,
    input  logic                outB_ready
`ifdef SVM_DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]    pkt_cnt_a,
    output logic [CNT_W-1:0]    pkt_cnt_b
`endif
);

    state_t state_q, state_d;
    logic   target;
    logic   free_a, free_b;
    logic   accept;
    logic   load_a, load_b;

    // Target lane: free choice in IDLE, locked while a packet is in flight.
    always_comb begin
        target = in_sel;
        case (state_q)
            ROUTE_A: target = LANE_A;
            ROUTE_B: target = LANE_B;
            default: target = in_sel;
        endcase
    end

    assign in_ready = (target == LANE_B) ? free_b : free_a;
    assign accept   = in_valid && in_ready;
    assign load_a   = accept && (target == LANE_A);
    assign load_b   = accept && (target == LANE_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A last beat always ends the lock; any other beat locks onto the lane
    // it went to (re-asserting the same lock when already routing).
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_last) begin
                state_d = IDLE;
            end else if (target == LANE_B) begin
                state_d = ROUTE_B;
            end else begin
                state_d = ROUTE_A;
            end
        end
    end

    svm_stream_reg #(.bitwidth(bitwidth)) u_lane_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_a),
        .load_data (in_data),
        .load_last (in_last),
        .slot_free (free_a),
        .out_data  (outA_data),
        .out_valid (outA_valid),
        .out_last  (outA_last),
        .out_ready (outA_ready)
    );

    svm_stream_reg #(.bitwidth(bitwidth)) u_lane_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_b),
        .load_data (in_data),
        .load_last (in_last),
        .slot_free (free_b),
        .out_data  (outB_data),
        .out_valid (outB_valid),
        .out_last  (outB_last),
        .out_ready (outB_ready)
    );

`ifdef SVM_DEMUX_STATS_EN
    // Packets are counted when their last beat is accepted, not when it
    // leaves the lane register; counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_a <= '0;
            pkt_cnt_b <= '0;
        end else begin
            if (load_a && in_last) pkt_cnt_a <= pkt_cnt_a + 1'b1;
            if (load_b && in_last) pkt_cnt_b <= pkt_cnt_b + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_svm_stream_demux.sv
// ----------------------------------------------------------------------------
// tb_svm_stream_demux
// Table of single-cycle vectors (inputs + expected in_ready and lane outputs
// after the edge), followed by hand-written reset-mid-packet and counter
// sequences.
// ----------------------------------------------------------------------------
module tb_svm_stream_demux;

    localparam int BW    = 25;
    localparam int CW    = 16;
    localparam int NVEC  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_sel = 1'b0;
    logic          in_ready;
    logic [BW-1:0] outA_data;
    logic          outA_valid;
    logic          outA_last;
    logic          outA_ready = 1'b1;
    logic [BW-1:0] outB_data;
    logic          outB_valid;
    logic          outB_last;
    logic          outB_ready = 1'b1;
`ifdef SVM_DEMUX_STATS_EN
    logic [CW-1:0] pkt_cnt_a;
    logic [CW-1:0] pkt_cnt_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    svm_stream_demux #(.bitwidth(BW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .outA_data  (outA_data),
        .outA_valid (outA_valid),
        .outA_last  (outA_last),
        .outA_ready (outA_ready),
        .outB_data  (outB_data),
        .outB_valid (outB_valid),
        .outB_last  (outB_last),
        .outB_ready (outB_ready)
`ifdef SVM_DEMUX_STATS_EN
        ,
        .pkt_cnt_a  (pkt_cnt_a),
        .pkt_cnt_b  (pkt_cnt_b)
`endif
    );

    typedef struct {
        logic          v, sel, last;
        logic [BW-1:0] d;
        logic          ra, rb;
        logic          x_rdy;
        logic          xav;
        logic [BW-1:0] xad;
        logic          xal;
        logic          xbv;
        logic [BW-1:0] xbd;
        logic          xbl;
    } vec_t;

    vec_t vecs[NVEC];

    function automatic vec_t mk(logic v, logic sel, logic last, logic [BW-1:0] d,
                                logic ra, logic rb, logic x_rdy,
                                logic xav, logic [BW-1:0] xad, logic xal,
                                logic xbv, logic [BW-1:0] xbd, logic xbl);
        vec_t r;
        r.v = v; r.sel = sel; r.last = last; r.d = d; r.ra = ra; r.rb = rb;
        r.x_rdy = x_rdy;
        r.xav = xav; r.xad = xad; r.xal = xal;
        r.xbv = xbv; r.xbd = xbd; r.xbl = xbl;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_lanes(input string tag, input vec_t t);
        check({tag, " outA_valid"}, 32'(outA_valid), 32'(t.xav));
        check({tag, " outA_data"},  32'(outA_data),  32'(t.xad));
        check({tag, " outA_last"},  32'(outA_last),  32'(t.xal));
        check({tag, " outB_valid"}, 32'(outB_valid), 32'(t.xbv));
        check({tag, " outB_data"},  32'(outB_data),  32'(t.xbd));
        check({tag, " outB_last"},  32'(outB_last),  32'(t.xbl));
    endtask

    task automatic drive(input logic v, input logic sel, input logic last, input logic [BW-1:0] d);
        in_valid = v; in_sel = sel; in_last = last; in_data = d;
    endtask

    initial begin
        //            v  s  l  data        ra rb rdy  Av Ad          Al  Bv Bd         Bl
        // route test: 3-beat packet to A
        vecs[0]  = mk(1, 0, 0, 25'h000001, 1, 1, 1,   1, 25'h000001, 0,  0, 25'h0,     0);
        vecs[1]  = mk(1, 0, 0, 25'h000002, 1, 1, 1,   1, 25'h000002, 0,  0, 25'h0,     0);
        vecs[2]  = mk(1, 0, 1, 25'h000003, 1, 1, 1,   1, 25'h000003, 1,  0, 25'h0,     0);
        vecs[3]  = mk(0, 0, 0, 25'h000000, 1, 1, 1,   0, 25'h000003, 1,  0, 25'h0,     0);
        // select lock: 4 beats to B with in_sel toggling after the first
        vecs[4]  = mk(1, 1, 0, 25'h000011, 1, 1, 1,   0, 25'h000003, 1,  1, 25'h11,    0);
        vecs[5]  = mk(1, 0, 0, 25'h000012, 1, 1, 1,   0, 25'h000003, 1,  1, 25'h12,    0);
        vecs[6]  = mk(1, 1, 0, 25'h000013, 1, 1, 1,   0, 25'h000003, 1,  1, 25'h13,    0);
        vecs[7]  = mk(1, 0, 1, 25'h000014, 1, 1, 1,   0, 25'h000003, 1,  1, 25'h14,    1);
        vecs[8]  = mk(1, 0, 1, 25'h000021, 1, 1, 1,   1, 25'h000021, 1,  0, 25'h14,    1);
        // single-beat packets alternating lanes, no bubbles
        vecs[9]  = mk(1, 1, 1, 25'h000031, 1, 1, 1,   0, 25'h000021, 1,  1, 25'h31,    1);
        vecs[10] = mk(1, 0, 1, 25'h000032, 1, 1, 1,   1, 25'h000032, 1,  0, 25'h31,    1);
        vecs[11] = mk(1, 1, 1, 25'h000033, 1, 1, 1,   0, 25'h000032, 1,  1, 25'h33,    1);
        vecs[12] = mk(1, 0, 1, 25'h000034, 1, 1, 1,   1, 25'h000034, 1,  0, 25'h33,    1);
        // independent backpressure: A holds 0x0ABCDE while B streams
        vecs[13] = mk(1, 0, 1, 25'h0ABCDE, 1, 1, 1,   1, 25'h0ABCDE, 1,  0, 25'h33,    1);
        vecs[14] = mk(1, 1, 0, 25'h000041, 0, 1, 1,   1, 25'h0ABCDE, 1,  1, 25'h41,    0);
        vecs[15] = mk(1, 0, 0, 25'h000042, 0, 1, 1,   1, 25'h0ABCDE, 1,  1, 25'h42,    0);
        vecs[16] = mk(1, 0, 1, 25'h000043, 0, 1, 1,   1, 25'h0ABCDE, 1,  1, 25'h43,    1);
        vecs[17] = mk(1, 0, 1, 25'h000044, 0, 1, 0,   1, 25'h0ABCDE, 1,  0, 25'h43,    1);
        vecs[18] = mk(1, 0, 1, 25'h000044, 1, 1, 1,   1, 25'h000044, 1,  0, 25'h43,    1);
        vecs[19] = mk(0, 0, 0, 25'h000000, 1, 1, 1,   0, 25'h000044, 1,  0, 25'h43,    1);

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outA_valid", 32'(outA_valid), 32'd0);
        check("reset outB_valid", 32'(outB_valid), 32'd0);
        check("reset outA_data",  32'(outA_data),  32'd0);
        check("reset outB_last",  32'(outB_last),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].sel, vecs[i].last, vecs[i].d);
            outA_ready = vecs[i].ra;
            outB_ready = vecs[i].rb;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].x_rdy));
            @(posedge clk);
            #1;
            check_lanes($sformatf("vec%0d", i), vecs[i]);
        end

        // reset in the middle of a 5-beat packet to B
        @(negedge clk);
        outA_ready = 1'b1; outB_ready = 1'b1;
        drive(1, 1, 0, 25'h000051);
        @(posedge clk); #1;
        check("rst_mid beat1 outB_data", 32'(outB_data), 32'h51);
        @(negedge clk);
        drive(1, 0, 0, 25'h000052);
        @(posedge clk); #1;
        check("rst_mid beat2 outB_data", 32'(outB_data), 32'h52);
        check("rst_mid beat2 outA_valid", 32'(outA_valid), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 25'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid outB_valid async", 32'(outB_valid), 32'd0);
        check("rst_mid outB_data async",  32'(outB_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 25'h000061);
        #1;
        check("rst_mid restart in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("rst_mid restart outA_valid", 32'(outA_valid), 32'd1);
        check("rst_mid restart outA_data",  32'(outA_data),  32'h61);
        check("rst_mid restart outB_valid", 32'(outB_valid), 32'd0);
        @(negedge clk);
        drive(1, 1, 1, 25'h000062);
        @(posedge clk); #1;
        check("rst_mid lockA outA_data",  32'(outA_data),  32'h62);
        check("rst_mid lockA outA_last",  32'(outA_last),  32'd1);
        check("rst_mid lockA outB_valid", 32'(outB_valid), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 25'h0);

`ifdef SVM_DEMUX_STATS_EN
        // packet counters: 3 packets to A (one multi-beat), 2 to B
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stats reset cnt_a", 32'(pkt_cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 25'h71); @(negedge clk);
        drive(1, 1, 1, 25'h72); @(negedge clk);
        drive(1, 0, 1, 25'h73); @(negedge clk);
        drive(1, 1, 1, 25'h74); @(negedge clk);
        drive(1, 0, 1, 25'h75); @(negedge clk);
        drive(1, 1, 1, 25'h76); @(negedge clk);
        drive(0, 0, 0, 25'h0);
        #1;
        check("stats cnt_a", 32'(pkt_cnt_a), 32'd3);
        check("stats cnt_b", 32'(pkt_cnt_b), 32'd2);
        // bring A to 2^CNT_W packets in total so it wraps to zero
        drive(1, 0, 1, 25'h80);
        repeat ((1 << CW) - 3) @(negedge clk);
        drive(0, 0, 0, 25'h0);
        #1;
        check("stats cnt_a wrap", 32'(pkt_cnt_a), 32'd0);
        check("stats cnt_b hold", 32'(pkt_cnt_b), 32'd2);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
